// File: rtl/dcache_ctrl_pkg.sv
// Shared types and address helpers for the data-cache miss/refill sequencer.
package dcache_ctrl_pkg;

  localparam int unsigned TAG_WIDTH    = 20;
  localparam int unsigned INDEX_WIDTH  = 7;
  localparam int unsigned OFFSET_WIDTH = 5;
  localparam int unsigned LINE_WIDTH   = 256;
  localparam int unsigned NUM_SETS     = 1 << INDEX_WIDTH;

  typedef logic [TAG_WIDTH-1:0]   tag_t;
  typedef logic [INDEX_WIDTH-1:0] index_t;
  typedef logic [LINE_WIDTH-1:0]  line_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_WAIT = 3'd2,
    RF_REQ  = 3'd3,
    RF_WAIT = 3'd4,
    REFRESH = 3'd5
  } state_t;

  function automatic tag_t addr_tag(input logic [31:0] addr);
    return addr[31 -: TAG_WIDTH];
  endfunction

  function automatic index_t addr_index(input logic [31:0] addr);
    return addr[OFFSET_WIDTH +: INDEX_WIDTH];
  endfunction

  function automatic logic [31:0] line_addr(input tag_t tag, input index_t index);
    return {tag, index, {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and AXI-bridge-side signals of the data-cache controller.
interface dcache_ctrl_if;
  import dcache_ctrl_pkg::*;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic        hit;
  logic        stall_req;
  logic        write_back;
  logic        write_req;
  logic [31:0] write_addr;
  logic        wr_done;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_done;
  line_t       rd_line;
  logic        refresh;
  line_t       cacheline_new;

  modport slave (
    input  sram_en, sram_wen, sram_addr, wr_done, rd_done, rd_line,
    output hit, stall_req, write_back, write_req, write_addr,
           rd_req, rd_addr, refresh, cacheline_new
  );

  modport master (
    output sram_en, sram_wen, sram_addr, wr_done, rd_done, rd_line,
    input  hit, stall_req, write_back, write_req, write_addr,
           rd_req, rd_addr, refresh, cacheline_new
  );

endinterface

// File: rtl/dcache_ctrl_meta.sv
// Tag/valid/dirty arrays: async read, single write port, sync active-low clear of valid/dirty.
module dcache_meta
  import dcache_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   clr_n,
  input  index_t rd_index,
  output tag_t   rd_tag,
  output logic   rd_valid,
  output logic   rd_dirty,
  input  index_t wr_index,
  input  logic   set_dirty,
  input  logic   refill_update,
  input  tag_t   refill_tag
);

  tag_t                tag_q [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];

  // Tags are intentionally left unreset; valid gates every use.
  always_ff @(posedge clk) begin
    if (refill_update) begin
      tag_q[wr_index] <= refill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill_update) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= 1'b0;
    end else if (set_dirty) begin
      dirty_q[wr_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Miss/refill sequencer for the direct-mapped 128-set, 32-byte-line data cache.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  dcache_ctrl_if.slave bus
);

  state_t      state;
  index_t      miss_index;
  tag_t        miss_tag;
  logic        write_req_q;
  logic        write_back_q;
  logic        rd_req_q;
  logic        refresh_q;
  logic [31:0] write_addr_q;
  logic [31:0] rd_addr_q;
  line_t       line_q;

  index_t req_index;
  tag_t   req_tag;
  tag_t   meta_tag;
  logic   meta_valid;
  logic   meta_dirty;
  logic   hit_c;
  logic   miss_c;
  logic   set_dirty_c;
  logic   refill_c;
  index_t meta_wr_index;

  assign req_index = addr_index(bus.sram_addr);
  assign req_tag   = addr_tag(bus.sram_addr);

  dcache_meta u_meta (
    .clk           (clk),
    .clr_n         (rst),
    .rd_index      (req_index),
    .rd_tag        (meta_tag),
    .rd_valid      (meta_valid),
    .rd_dirty      (meta_dirty),
    .wr_index      (meta_wr_index),
    .set_dirty     (set_dirty_c),
    .refill_update (refill_c),
    .refill_tag    (miss_tag)
  );

  assign hit_c         = bus.sram_en && meta_valid && (meta_tag == req_tag);
  assign miss_c        = (state == IDLE) && bus.sram_en && !hit_c;
  assign set_dirty_c   = (state == IDLE) && hit_c && (bus.sram_wen != '0);
  assign refill_c      = (state == REFRESH);
  assign meta_wr_index = refill_c ? miss_index : req_index;

  assign bus.hit           = hit_c;
  assign bus.stall_req     = (state != IDLE) || miss_c;
  assign bus.write_back    = write_back_q;
  assign bus.write_req     = write_req_q;
  assign bus.write_addr    = write_addr_q;
  assign bus.rd_req        = rd_req_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.refresh       = refresh_q;
  assign bus.cacheline_new = line_q;

  // Request outputs are set on the transition into their state so they are
  // visible from the first cycle of that state; rd_done is accepted in RF_REQ
  // already, which gives the 4-cycle clean miss with a zero-wait bridge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      write_req_q  <= 1'b0;
      write_back_q <= 1'b0;
      rd_req_q     <= 1'b0;
      refresh_q    <= 1'b0;
      line_q       <= '0;
    end else begin
      write_req_q <= 1'b0;
      refresh_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_c) begin
            miss_index   <= req_index;
            miss_tag     <= req_tag;
            write_addr_q <= line_addr(meta_tag, req_index);
            rd_addr_q    <= line_addr(req_tag, req_index);
            if (meta_valid && meta_dirty) begin
              state        <= WB_REQ;
              write_req_q  <= 1'b1;
              write_back_q <= 1'b1;
            end else begin
              state    <= RF_REQ;
              rd_req_q <= 1'b1;
            end
          end
        end
        WB_REQ, WB_WAIT: begin
          if (bus.wr_done) begin
            state        <= RF_REQ;
            write_back_q <= 1'b0;
            rd_req_q     <= 1'b1;
          end else begin
            state <= WB_WAIT;
          end
        end
        RF_REQ, RF_WAIT: begin
          if (bus.rd_done) begin
            state     <= REFRESH;
            line_q    <= bus.rd_line;
            rd_req_q  <= 1'b0;
            refresh_q <= 1'b1;
          end else begin
            state <= RF_WAIT;
          end
        end
        REFRESH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed and randomized bench for dcache_ctrl with a set-level cache model and bridge responder.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  bit           m_valid [128];
  bit           m_dirty [128];
  logic [19:0]  m_tag   [128];
  logic [255:0] last_line = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // The CPU side must hold sram_addr while the controller stalls.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = '0;
  always @(negedge clk) begin
    if (rst === 1'b1 && prev_stall) begin
      checks++;
      assert (bus.sram_addr === prev_addr) else begin
        errors++;
        $error("FAIL addr_stable: observed=%0h expected=%0h", bus.sram_addr, prev_addr);
      end
    end
    prev_stall = bus.stall_req;
    prev_addr  = bus.sram_addr;
  end

  // Called at posedge+1; returns at posedge+1 after the access has completed.
  task automatic access(input logic [31:0] addr, input logic [3:0] wen,
                        input int unsigned wlat, input int unsigned rlat,
                        input logic [255:0] line, input bit stray_wr);
    logic [6:0]  idx;
    logic [19:0] tg;
    logic [31:0] vaddr;
    bit exp_hit, exp_wb, wpend, rpend, rgiven, wgiven, wacked, stray_done, done;
    int unsigned t, n_wreq, n_ref, wcnt, rcnt, rfirst, exp_t;
    idx = addr[11:5];
    tg  = addr[31:12];
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
    vaddr   = {m_tag[idx], idx, 5'b0};
    bus.sram_en = 1'b1; bus.sram_addr = addr; bus.sram_wen = wen;
    @(negedge clk);
    chk("hit", 256'(bus.hit), 256'(exp_hit));
    chk("stall", 256'(bus.stall_req), 256'(!exp_hit));
    if (!exp_hit) begin
      wpend = 0; rpend = 0; rgiven = 0; wgiven = 0; wacked = 0; stray_done = 0; done = 0;
      t = 0; n_wreq = 0; n_ref = 0; wcnt = 0; rcnt = 0; rfirst = 0;
      while (!done && t < 100) begin
        @(posedge clk); #1; t++;
        if (wgiven) wacked = 1;
        bus.wr_done = 1'b0; bus.rd_done = 1'b0; bus.rd_line = rand_line();
        if (bus.write_req) begin
          n_wreq++;
          chk("write_addr", 256'(bus.write_addr), 256'(vaddr));
          chk("write_back", 256'(bus.write_back), 256'(1));
          wpend = 1; wcnt = wlat;
        end
        if (wpend) begin
          if (wcnt == 0) begin bus.wr_done = 1'b1; wpend = 0; wgiven = 1; end
          else wcnt--;
        end
        if (exp_wb && !wacked) chk("rd_req_early", 256'(bus.rd_req), 256'(0));
        if (bus.rd_req && !rpend && !rgiven) begin
          chk("rd_addr", 256'(bus.rd_addr), 256'({addr[31:5], 5'b0}));
          chk("wb_low_in_refill", 256'(bus.write_back), 256'(0));
          rpend = 1; rcnt = rlat; rfirst = t;
        end
        if (rpend) begin
          if (rcnt == 0) begin bus.rd_done = 1'b1; bus.rd_line = line; rpend = 0; rgiven = 1; end
          else rcnt--;
        end
        if (stray_wr && !stray_done && rpend && t > rfirst && !bus.wr_done) begin
          bus.wr_done = 1'b1; stray_done = 1;
        end
        if (bus.refresh) begin
          n_ref++;
          chk("cacheline_new", bus.cacheline_new, line);
        end
        @(negedge clk);
        if (!bus.stall_req) done = 1;
      end
      exp_t = exp_wb ? wlat + rlat + 4 : rlat + 3;
      chk("miss_done", 256'(done), 256'(1));
      chk("latency", 256'(t), 256'(exp_t));
      chk("write_req_count", 256'(n_wreq), 256'(exp_wb));
      chk("refresh_count", 256'(n_ref), 256'(1));
      chk("hit_after_refill", 256'(bus.hit), 256'(1));
      m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0;
      last_line = line;
    end
    if (wen != 4'h0) m_dirty[idx] = 1;
    @(posedge clk); #1;
    bus.wr_done = 1'b0; bus.rd_done = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.sram_en = 1'b0; bus.sram_wen = 4'h0;
    @(negedge clk);
    chk("idle_stall", 256'(bus.stall_req), 256'(0));
    chk("idle_hit", 256'(bus.hit), 256'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    logic [19:0]  rt;
    logic [6:0]   ri;
    bus.sram_en = 1'b0; bus.sram_wen = 4'h0; bus.sram_addr = 32'h0;
    bus.wr_done = 1'b0; bus.rd_done = 1'b0; bus.rd_line = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write_req", 256'(bus.write_req), 256'(0));
    chk("rst_rd_req", 256'(bus.rd_req), 256'(0));
    chk("rst_refresh", 256'(bus.refresh), 256'(0));
    chk("rst_write_back", 256'(bus.write_back), 256'(0));
    chk("rst_cacheline_new", bus.cacheline_new, 256'(0));
    chk("rst_stall", 256'(bus.stall_req), 256'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Cold load, bridge answers 3 cycles after the request appears.
    l = rand_line(); l[95:64] = 32'hDEADBEEF;
    access(32'h0000_1040, 4'h0, 0, 3, l, 0);
    access(32'h0000_1044, 4'hF, 0, 0, rand_line(), 0);
    access(32'h0000_1044, 4'h0, 0, 0, rand_line(), 0);
    // Dirty victim at index 2 must be written back before the refill.
    access(32'h0000_2040, 4'h0, 2, 1, rand_line(), 0);
    // Clean victim, zero-wait bridge.
    access(32'h0000_1040, 4'h0, 0, 0, rand_line(), 0);
    idle_cycle();

    // Stray bridge completions in IDLE must be ignored.
    bus.sram_en = 1'b0; bus.rd_done = 1'b1; bus.wr_done = 1'b1; bus.rd_line = rand_line();
    @(posedge clk); #1;
    bus.rd_done = 1'b0; bus.wr_done = 1'b0;
    chk("stray_refresh", 256'(bus.refresh), 256'(0));
    chk("stray_rd_req", 256'(bus.rd_req), 256'(0));
    chk("stray_write_req", 256'(bus.write_req), 256'(0));
    chk("stray_line", bus.cacheline_new, last_line);
    chk("stray_stall", 256'(bus.stall_req), 256'(0));

    // Stray wr_done while waiting for the refill.
    access(32'h0000_5060, 4'h3, 0, 3, rand_line(), 1);

    // Reset in the middle of a refill.
    bus.sram_en = 1'b1; bus.sram_addr = 32'h0000_3080; bus.sram_wen = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rf_wait_rd_req", 256'(bus.rd_req), 256'(1));
    rst = 1'b0; bus.sram_en = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rd_req", 256'(bus.rd_req), 256'(0));
    chk("midrst_refresh", 256'(bus.refresh), 256'(0));
    chk("midrst_write_back", 256'(bus.write_back), 256'(0));
    chk("midrst_line", bus.cacheline_new, 256'(0));
    chk("midrst_stall", 256'(bus.stall_req), 256'(0));
    rst = 1'b1;
    for (int i = 0; i < 128; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    last_line = '0;
    @(posedge clk); #1;
    access(32'h0000_1040, 4'h0, 0, 0, rand_line(), 0);

    // Randomized traffic over a few conflicting tags and sets.
    for (int n = 0; n < 60; n++) begin
      rt = 20'($urandom_range(1, 3));
      ri = 7'($urandom_range(0, 3));
      a  = {rt, ri, 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 5) == 0) idle_cycle();
      access(a, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
             $urandom_range(0, 3), $urandom_range(0, 3), rand_line(),
             $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Miss/refill sequencer for the direct-mapped, single-way, 128-set, 32-byte-line data cache.
- Owns the tag, valid and dirty arrays and performs hit detection.
- On a miss it stalls the pipeline, writes back a dirty victim, refills the line through the AXI bridge, and pulses refresh into the data array. The stalled request then re-issues as a hit.

Parameters:
- TAG_WIDTH, 20, address tag bits [31:12].
- INDEX_WIDTH, 7, set index bits [11:5]; 2^INDEX_WIDTH sets.
- OFFSET_WIDTH, 5, byte offset bits [4:0].
- LINE_WIDTH, 256, cacheline bits (8 words).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- sram_en  in  1  CPU access valid
- sram_wen  in  4  byte write enables; 0 means load
- sram_addr  in  32  access address; held stable by CPU while stall_req=1
- hit  out  1  combinational: valid[index] && tag[index]==sram_addr[31:12] && sram_en
- stall_req  out  1  combinational: request pipeline stop
- write_back  out  1  victim line is being written back (WB_REQ/WB_WAIT)
- write_req  out  1  one-cycle pulse to AXI bridge to start line write
- write_addr  out  32  {victim_tag, index, 5'b0}
- wr_done  in  1  bridge pulse: write burst complete
- rd_req  out  1  level; held until rd_done
- rd_addr  out  32  {sram_addr[31:5], 5'b0}
- rd_done  in  1  bridge pulse; rd_line valid this cycle
- rd_line  in  LINE_WIDTH  refilled line, word 0 in bits [31:0]
- refresh  out  1  one-cycle pulse: data array writes whole line
- cacheline_new  out  LINE_WIDTH  registered copy of rd_line

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; all valid and dirty bits cleared; tags left unreset.
  - Outputs write_req, rd_req, refresh and write_back are 0; cacheline_new=0.
- States: IDLE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, REFRESH.
- IDLE:
  - Hit: stall_req=0. A store hit (sram_wen!=0) sets dirty[index] at the next edge.
  - Miss (sram_en && !hit): stall_req=1 the same cycle. Latch index and victim tag.
  - Next state is WB_REQ if valid&&dirty, else RF_REQ.
  - sram_en=0: stall_req=0; no state change.
- WB_REQ:
  - write_req=1 for exactly one cycle, write_back=1, then go to WB_WAIT.
  - cacheline_old comes from the data array, which is addressed by the held sram_addr index.
- WB_WAIT:
  - write_back=1; wait for wr_done, then go to RF_REQ.
  - wr_done arriving in the same cycle as the write_req pulse is legal; it is accepted and the FSM moves to RF_REQ next.
- RF_REQ/RF_WAIT:
  - rd_req=1 from RF_REQ until the cycle rd_done is seen.
  - On rd_done, capture rd_line into cacheline_new and go to REFRESH.
- REFRESH:
  - refresh=1 for one cycle.
  - Update tag[index]=sram_addr[31:12], valid=1, dirty=0.
  - Go to IDLE. The held request hits on the next cycle; a store then sets dirty.
- stall_req=1 in every non-IDLE state.
- Minimum miss latency, clean victim: miss cycle, RF_REQ, bridge latency, REFRESH, then hit cycle. With a zero-wait bridge that is 4 cycles from miss to hit.
- No cancellation: flush and branch do not abort an in-flight miss; the transaction always completes.
- Stray wr_done or rd_done outside the matching wait state is ignored.
- Reset mid-miss returns to IDLE immediately. Any outstanding bridge transaction is the bridge's concern, since it shares the reset.
- sram_addr must not change while stall_req=1. The bench checks this with an assertion.

Decomposition:
- Shared defines header (existing defines.vh) holds:
  - CACHELINE_WIDTH and TAG_WIDTH
  - state encodings (3-bit localparams)
  - address field slice macros
- One natural sub-module: dcache_meta. It holds the tag/valid/dirty register arrays and has:
  - an asynchronous read port
  - a write port (set_dirty, refill_update)
  - a synchronous active-low clear
- The FSM stays in dcache_ctrl.

Test Plan:
- Cold load of addr 0x0000_1040 after reset: miss. rd_req high with rd_addr=0x0000_1040. Bridge gives rd_done at +3 with line word2=0xDEADBEEF. Expect one refresh pulse, stall_req low the cycle after REFRESH, and hit=1.
- Store hit to 0x0000_1044 (wen=4'hF): no stall; dirty[index 2] becomes 1. A following load to 0x0000_1044 hits with no stall.
- Conflict load to 0x0000_2040 with the dirty victim:
  - write_req pulses once with write_addr=0x0000_1040 and write_back=1.
  - No rd_req until wr_done.
  - Then rd_addr=0x0000_2040, refresh, tag=0x2, dirty=0.
- Conflict load to a clean line: no write_req. Zero-wait bridge gives a 4-cycle miss-to-hit.
- Reset asserted (rst=0) during RF_WAIT: next cycle state=IDLE, rd_req=0, all valid cleared. A re-access then misses.
- Spurious rd_done pulse in IDLE and wr_done in RF_WAIT: no state change and no refresh.
